// File: rtl/cop0_regfile.sv
// CP0 architectural register file: Status/Cause/EPC/BadVAddr state, Count/Compare
// timer, exception capture and masked interrupt-pending generation.
module cop0_regfile #(
  parameter logic [31:0] PRID         = 32'h0001_8000,
  parameter logic [31:0] CONFIG       = 32'h8000_0000,
  parameter logic [31:0] STATUS_WMASK = 32'h1040_FF17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [2:0]  wsel,
  input  logic [31:0] wd,
  input  logic [4:0]  ra,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic        exc_bd,
  input  logic [31:0] exc_pc,
  input  logic        exc_badvaddr_valid,
  input  logic [31:0] exc_badvaddr,
  input  logic [5:0]  hw_int,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        timer_int,
  output logic        irq_pending
);

  localparam logic [4:0] R_BADVADDR = 5'd8,  R_COUNT  = 5'd9,  R_COMPARE = 5'd11,
                         R_STATUS   = 5'd12, R_CAUSE  = 5'd13, R_EPC     = 5'd14,
                         R_PRID     = 5'd15, R_CONFIG = 5'd16;
  localparam logic [31:0] STATUS_RST = 32'h0040_0004;

  logic [31:0] status_r, cause_r, epc_r, badvaddr_r, count_r, compare_r;
  logic        cnt_phase;

  logic        wr_sel0, wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] count_nxt;
  logic        match, ti_next;

  assign wr_sel0     = we && (wsel == 3'd0);
  assign wr_badvaddr = wr_sel0 && (wa == R_BADVADDR);
  assign wr_count    = wr_sel0 && (wa == R_COUNT);
  assign wr_compare  = wr_sel0 && (wa == R_COMPARE);
  assign wr_status   = wr_sel0 && (wa == R_STATUS);
  assign wr_cause    = wr_sel0 && (wa == R_CAUSE);
  assign wr_epc      = wr_sel0 && (wa == R_EPC);

  // A Count write suppresses both the increment and the match check.
  assign count_nxt = count_r + 32'd1;
  assign match     = cnt_phase && !wr_count && (count_nxt == compare_r);
  assign ti_next   = wr_compare ? 1'b0 : (match | cause_r[30]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_r   <= STATUS_RST;
      cause_r    <= '0;
      epc_r      <= '0;
      badvaddr_r <= '0;
      count_r    <= '0;
      compare_r  <= '0;
      cnt_phase  <= 1'b0;
    end else begin
      if (wr_status) status_r <= (status_r & ~STATUS_WMASK) | (wd & STATUS_WMASK);
      if (wr_compare) compare_r <= wd;

      if (wr_count) begin
        count_r   <= wd;
        cnt_phase <= 1'b0;
      end else begin
        cnt_phase <= ~cnt_phase;
        if (cnt_phase) count_r <= count_nxt;
      end

      cause_r[30]    <= ti_next;
      cause_r[15:10] <= {hw_int[5] | ti_next, hw_int[4:0]};
      if (wr_cause) cause_r[9:8] <= wd[9:8];

      // The exception port owns EPC and BadVAddr in its commit cycle.
      if (exc_valid) begin
        cause_r[6:2] <= exc_code;
        if (!status_r[1]) begin
          epc_r       <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          cause_r[31] <= exc_bd;
        end
        if (exc_badvaddr_valid) badvaddr_r <= exc_badvaddr;
      end else begin
        if (wr_epc)      epc_r      <= wd;
        if (wr_badvaddr) badvaddr_r <= wd;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rsel == 3'd0) begin
      case (ra)
        R_BADVADDR: rdata = badvaddr_r;
        R_COUNT:    rdata = count_r;
        R_COMPARE:  rdata = compare_r;
        R_STATUS:   rdata = status_r;
        R_CAUSE:    rdata = cause_r;
        R_EPC:      rdata = epc_r;
        R_PRID:     rdata = PRID;
        R_CONFIG:   rdata = CONFIG;
        default:    rdata = '0;
      endcase
    end
  end

  assign status      = status_r;
  assign cause       = cause_r;
  assign epc         = epc_r;
  assign timer_int   = cause_r[30];
  assign irq_pending = (|(cause_r[15:8] & status_r[15:8])) & status_r[0] & ~status_r[1] & ~status_r[2];

endmodule

// File: tb/tb_cop0_regfile.sv
// Bench for cop0_regfile: directed scenarios plus randomized traffic against a
// cycle-level architectural model of the CP0 registers.
module tb_cop0_regfile;
  localparam logic [31:0] PRID = 32'h0001_8000, CONFIG = 32'h8000_0000, WMASK = 32'h1040_FF17;

  logic        clk = 0, reset_n = 0;
  logic        we = 0;
  logic [4:0]  wa = 0, ra = 0;
  logic [2:0]  wsel = 0, rsel = 0;
  logic [31:0] wd = 0, rdata;
  logic        exc_valid = 0, exc_bd = 0, exc_badvaddr_valid = 0;
  logic [4:0]  exc_code = 0;
  logic [31:0] exc_pc = 0, exc_badvaddr = 0;
  logic [5:0]  hw_int = 0;
  logic [31:0] status, cause, epc;
  logic        timer_int, irq_pending;

  int vectors = 0, errors = 0;

  cop0_regfile dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wsel(wsel), .wd(wd),
    .ra(ra), .rsel(rsel), .rdata(rdata), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_bd(exc_bd), .exc_pc(exc_pc), .exc_badvaddr_valid(exc_badvaddr_valid),
    .exc_badvaddr(exc_badvaddr), .hw_int(hw_int), .status(status), .cause(cause),
    .epc(epc), .timer_int(timer_int), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  // Architectural model, kept as named fields rather than a packed Cause word.
  logic [31:0] m_status, m_epc, m_bva, m_count, m_compare;
  logic        m_phase, m_ti, m_bd;
  logic [7:0]  m_ip;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic m_irq();
    return (|(m_ip & m_status[15:8])) && m_status[0] && !m_status[1] && !m_status[2];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
    if (s != 0) return 0;
    case (r)
      8: return m_bva;       9: return m_count;    11: return m_compare;
      12: return m_status;  13: return m_cause();  14: return m_epc;
      15: return PRID;      16: return CONFIG;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0004; m_epc = 0; m_bva = 0; m_count = 0; m_compare = 0;
    m_phase = 0; m_ti = 0; m_bd = 0; m_ip = 0; m_exc = 0;
  endtask

  // Advance one clock, applying the architectural rules to the model.
  task automatic step();
    logic wr;
    logic [31:0] n_status, n_epc, n_bva, n_count, n_compare;
    logic n_phase, n_ti, n_bd, hit;
    logic [7:0] n_ip;
    logic [4:0] n_exc;
    wr = we && wsel == 0;
    n_status = m_status; n_epc = m_epc; n_bva = m_bva; n_count = m_count;
    n_compare = m_compare; n_phase = !m_phase; n_ti = m_ti; n_bd = m_bd;
    n_ip = m_ip; n_exc = m_exc; hit = 0;
    if (wr && wa == 12) n_status = (m_status & ~WMASK) | (wd & WMASK);
    if (wr && wa == 9) begin
      n_count = wd; n_phase = 0;
    end else if (m_phase) begin
      n_count = m_count + 1;
      hit = (n_count == m_compare);
    end
    if (wr && wa == 11) begin n_compare = wd; n_ti = 0; end
    else if (hit) n_ti = 1;
    n_ip[7:2] = {hw_int[5] | n_ti, hw_int[4:0]};
    if (wr && wa == 13) n_ip[1:0] = wd[9:8];
    if (exc_valid) begin
      n_exc = exc_code;
      if (!m_status[1]) begin
        n_epc = exc_bd ? exc_pc - 4 : exc_pc;
        n_bd = exc_bd;
      end
      if (exc_badvaddr_valid) n_bva = exc_badvaddr;
    end else begin
      if (wr && wa == 14) n_epc = wd;
      if (wr && wa == 8) n_bva = wd;
    end
    @(posedge clk);
    #1;
    m_status = n_status; m_epc = n_epc; m_bva = n_bva; m_count = n_count;
    m_compare = n_compare; m_phase = n_phase; m_ti = n_ti; m_bd = n_bd;
    m_ip = n_ip; m_exc = n_exc;
  endtask

  task automatic idle();
    we = 0; exc_valid = 0; exc_badvaddr_valid = 0; exc_bd = 0;
  endtask

  task automatic wr_reg(input logic [4:0] r, input logic [31:0] d);
    we = 1; wa = r; wsel = 0; wd = d;
    step();
    we = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); hw_int = 0; model_reset();
    #12;
    ra = 15; rsel = 0; #1;
    vectors++; if (status !== 32'h0040_0004) begin errors++; $display("FAIL reset_status got %h exp %h", status, 32'h0040_0004); end
    vectors++; if (cause !== 0 || epc !== 0) begin errors++; $display("FAIL reset_cause_epc got %h/%h exp 0/0", cause, epc); end
    vectors++; if (timer_int !== 0 || irq_pending !== 0) begin errors++; $display("FAIL reset_int got %b%b exp 00", timer_int, irq_pending); end
    vectors++; if (rdata !== PRID) begin errors++; $display("FAIL reset_prid got %h exp %h", rdata, PRID); end
    ra = 9; #1;
    vectors++; if (rdata !== 0) begin errors++; $display("FAIL reset_count got %h exp 0", rdata); end
    ra = 16; #1;
    vectors++; if (rdata !== CONFIG) begin errors++; $display("FAIL reset_config got %h exp %h", rdata, CONFIG); end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    m_phase = 1; // one edge elapsed out of reset
  endtask

  task automatic test_status_write();
    wr_reg(12, 32'h0000_FF01);
    vectors++; if (status !== 32'h0000_FF01) begin errors++; $display("FAIL status_write got %h exp %h", status, 32'h0000_FF01); end
  endtask

  task automatic test_timer();
    wr_reg(11, 8);
    wr_reg(9, 5);
    ra = 9; rsel = 0;
    step(); step(); #1;
    vectors++; if (rdata !== 6) begin errors++; $display("FAIL count_plus1 got %0d exp 6", rdata); end
    repeat (4) step();
    #1;
    vectors++; if (rdata !== 8) begin errors++; $display("FAIL count_plus3 got %0d exp 8", rdata); end
    vectors++; if (timer_int !== 1 || cause[15] !== 1) begin errors++; $display("FAIL timer_match got ti=%b ip7=%b exp 1 1", timer_int, cause[15]); end
    wr_reg(12, 32'h0000_8001);
    vectors++; if (irq_pending !== 1) begin errors++; $display("FAIL irq_timer got %b exp 1", irq_pending); end
    wr_reg(11, 32'h0000_1000);
    vectors++; if (timer_int !== 0) begin errors++; $display("FAIL compare_clear got %b exp 0", timer_int); end
  endtask

  task automatic test_exception();
    exc_valid = 1; exc_code = 5'h04; exc_bd = 1; exc_pc = 32'h8000_0104;
    exc_badvaddr_valid = 1; exc_badvaddr = 32'h1234_5671;
    step(); idle();
    ra = 8; #1;
    vectors++; if (epc !== 32'h8000_0100) begin errors++; $display("FAIL exc_epc got %h exp %h", epc, 32'h8000_0100); end
    vectors++; if (cause[31] !== 1 || cause[6:2] !== 5'h04) begin errors++; $display("FAIL exc_cause got bd=%b code=%h exp 1 04", cause[31], cause[6:2]); end
    vectors++; if (rdata !== 32'h1234_5671) begin errors++; $display("FAIL exc_badvaddr got %h exp %h", rdata, 32'h1234_5671); end
    wr_reg(12, 32'h0000_8003);
    exc_valid = 1; exc_code = 5'h0C; exc_bd = 0; exc_pc = 32'h8000_0200;
    step(); idle();
    vectors++; if (epc !== 32'h8000_0100 || cause[6:2] !== 5'h0C) begin errors++; $display("FAIL exc_nested got epc=%h code=%h exp 80000100 0c", epc, cause[6:2]); end
    wr_reg(12, 32'h0000_8001);
    we = 1; wa = 14; wsel = 0; wd = 32'hDEAD_BEEF;
    exc_valid = 1; exc_code = 5'h08; exc_bd = 0; exc_pc = 32'h8000_0300;
    step(); idle();
    vectors++; if (epc !== 32'h8000_0300) begin errors++; $display("FAIL exc_vs_mtc0 got %h exp %h", epc, 32'h8000_0300); end
  endtask

  task automatic test_wrap_and_reset();
    wr_reg(11, 0);
    wr_reg(9, 32'hFFFF_FFFF);
    ra = 9; rsel = 0;
    step(); step(); #1;
    vectors++; if (rdata !== 0 || timer_int !== 1) begin errors++; $display("FAIL count_wrap got %h ti=%b exp 0 1", rdata, timer_int); end
    repeat (5) step();
    #2 reset_n = 0; #1;
    vectors++; if (rdata !== 0 || timer_int !== 0 || status !== 32'h0040_0004) begin errors++; $display("FAIL async_reset got count=%h ti=%b st=%h", rdata, timer_int, status); end
    model_reset();
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    m_phase = 1;
    wr_reg(20, 32'hFFFF_FFFF);
    ra = 20; #1;
    vectors++; if (rdata !== 0) begin errors++; $display("FAIL unimpl_reg got %h exp 0", rdata); end
    ra = 12; rsel = 1; #1;
    vectors++; if (rdata !== 0) begin errors++; $display("FAIL nonzero_sel got %h exp 0", rdata); end
    rsel = 0;
  endtask

  task automatic test_random();
    logic [4:0] regs [10] = '{8, 9, 11, 12, 13, 14, 15, 16, 20, 0};
    logic [31:0] exp_r;
    for (int i = 0; i < 400; i++) begin
      hw_int = 6'($urandom);
      we = ($urandom_range(0, 2) == 0);
      wa = regs[$urandom_range(0, 9)];
      wsel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      wd = $urandom;
      if (wa == 9 && $urandom_range(0, 1) == 1) wd = m_compare - 32'($urandom_range(1, 3));
      exc_valid = ($urandom_range(0, 5) == 0);
      exc_code = 5'($urandom); exc_bd = 1'($urandom);
      exc_pc = $urandom & 32'hFFFF_FFFC;
      exc_badvaddr_valid = 1'($urandom); exc_badvaddr = $urandom;
      if (exc_valid && (wa == 8 || wa == 14)) we = 0;
      ra = regs[$urandom_range(0, 9)];
      rsel = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd0;
      step();
      exp_r = m_read(ra, rsel);
      vectors++;
      if (status !== m_status || cause !== m_cause() || epc !== m_epc) begin
        errors++; $display("FAIL rand_regs cyc %0d got %h/%h/%h exp %h/%h/%h", i, status, cause, epc, m_status, m_cause(), m_epc);
      end
      vectors++;
      if (rdata !== exp_r || timer_int !== m_ti || irq_pending !== m_irq()) begin
        errors++; $display("FAIL rand_read cyc %0d r%0d/%0d got %h ti=%b irq=%b exp %h %b %b", i, ra, rsel, rdata, timer_int, irq_pending, exp_r, m_ti, m_irq());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_status_write();
    test_timer();
    test_exception();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
